// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and a counter-width helper.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic STAGES-deep, DATA_W-wide shift register with clock enable and sync reset value.
module vga_delay_line #(
  parameter int                STAGES  = 2,
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [DATA_W-1:0] stage_q [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else if (ce) begin
          stage_q[0] <= din;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and registered RGB output stage.
// Optional vblank interrupt enabled by defining VGA_VBLANK_IRQ_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 3,
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2,
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_W       = cnt_w(H_TOTAL),
  localparam int V_W       = cnt_w(V_TOTAL)
) (
  input  logic                  CLK100MHz,
  input  logic                  rst,
  input  logic                  double_scan_req,
  input  logic [COLOR_BITS-1:0] pix_r_in,
  input  logic [COLOR_BITS-1:0] pix_g_in,
  input  logic [COLOR_BITS-1:0] pix_b_in,
  input  logic                  irq_ack,
  output logic [H_W-1:0]        pix_x,
  output logic [V_W-1:0]        pix_y,
  output logic                  pix_active,
  output logic                  pix_en,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b,
  output logic                  irq
);

  localparam int DIV_W    = cnt_w(CLK_DIV);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             mode;
  logic             h_wrap, v_wrap;

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == V_W'(V_TOTAL - 1));

  always_ff @(posedge CLK100MHz) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= pix_en ? '0 : div_cnt + DIV_W'(1);
      line_start  <= pix_en && h_wrap;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + H_W'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + V_W'(1);
          // Doubling mode only switches on the frame wrap so a frame is never mixed.
          if (v_wrap) mode <= double_scan_req;
        end
      end
    end
  end

  assign pix_x      = mode ? (h_cnt >> 1) : h_cnt;
  assign pix_y      = mode ? (v_cnt >> 1) : v_cnt;
  assign pix_active = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);

  // Stage p0: raw sync/active from the counters
  logic hs_p0, vs_p0;
  assign hs_p0 = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
  assign vs_p0 = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

  // Stage p1: aligned with the colour returned by the fetch pipeline
  logic hs_p1, vs_p1, act_p1;

  vga_delay_line #(
    .STAGES (PIPE_DELAY),
    .DATA_W (3),
    .RST_VAL(3'b000)
  ) u_sync_dly (
    .clk (CLK100MHz),
    .rst (rst),
    .ce  (pix_en),
    .din ({hs_p0, vs_p0, pix_active}),
    .dout({hs_p1, vs_p1, act_p1})
  );

  // Stage p2: registered, blanked pin outputs
  always_ff @(posedge CLK100MHz) begin
    if (rst) begin
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (pix_en) begin
      vga_hs <= hs_p1 ? HS_POL : ~HS_POL;
      vga_vs <= vs_p1 ? VS_POL : ~VS_POL;
      vga_r  <= act_p1 ? pix_r_in : '0;
      vga_g  <= act_p1 ? pix_g_in : '0;
      vga_b  <= act_p1 ? pix_b_in : '0;
    end
  end

`ifdef VGA_VBLANK_IRQ_EN
  logic vblank_set;
  assign vblank_set = pix_en && h_wrap && (v_cnt == V_W'(V_VISIBLE - 1));

  // Set has priority so an ack racing the vblank edge cannot lose it.
  always_ff @(posedge CLK100MHz) begin
    if (rst)             irq <= 1'b0;
    else if (vblank_set) irq <= 1'b1;
    else if (irq_ack)    irq <= 1'b0;
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a pixel-index arithmetic reference model.
module tb_vga_timing_gen;

  localparam int CB   = 3;
  localparam int DIV  = 2;
  localparam int HV   = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV   = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT   = HV + HF + HS + HB;
  localparam int VT   = VV + VF + VS + VB;
  localparam int PD   = 2;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int HW   = vga_pkg::cnt_w(HT);
  localparam int VW   = vga_pkg::cnt_w(VT);
  localparam int NCYC = 30000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          double_scan_req = 1'b0;
  logic [CB-1:0] pix_r_in = '0, pix_g_in = '0, pix_b_in = '0;
  logic          irq_ack = 1'b0;
  logic [HW-1:0] pix_x;
  logic [VW-1:0] pix_y;
  logic          pix_active, pix_en, line_start, frame_start;
  logic          vga_hs, vga_vs, irq;
  logic [CB-1:0] vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .COLOR_BITS(CB), .CLK_DIV(DIV),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HPOL), .VS_POL(VPOL), .PIPE_DELAY(PD)
  ) dut (
    .CLK100MHz(clk), .rst(rst), .double_scan_req(double_scan_req),
    .pix_r_in(pix_r_in), .pix_g_in(pix_g_in), .pix_b_in(pix_b_in),
    .irq_ack(irq_ack), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .pix_en(pix_en), .line_start(line_start), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything derives from clocks elapsed since reset.
  int m_clk, m_mode, m_irq, m_ls, m_fs, m_hs, m_vs, m_r, m_g, m_b;

  function automatic int h_of(input int n); return n % HT; endfunction
  function automatic int v_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit act_of(input int n);
    return (n >= 0) && (h_of(n) < HV) && (v_of(n) < VV);
  endfunction
  function automatic bit hs_of(input int n);
    return (n >= 0) && (h_of(n) >= HV + HF) && (h_of(n) < HV + HF + HS);
  endfunction
  function automatic bit vs_of(input int n);
    return (n >= 0) && (v_of(n) >= VV + VF) && (v_of(n) < VV + VF + VS);
  endfunction

  task automatic model_reset();
    m_clk = 0; m_mode = 0; m_irq = 0; m_ls = 0; m_fs = 0;
    m_hs = 32'(!HPOL); m_vs = 32'(!VPOL); m_r = 0; m_g = 0; m_b = 0;
  endtask

  // Called just after a rising edge; inputs still hold the values sampled there.
  task automatic model_step();
    int n;
    bit pe;
    if (rst) begin
      model_reset();
      return;
    end
    n  = m_clk / DIV;
    pe = (m_clk % DIV) == DIV - 1;
    m_ls = int'(pe && h_of(n + 1) == 0);
    m_fs = int'(pe && h_of(n + 1) == 0 && v_of(n + 1) == 0);
`ifdef VGA_VBLANK_IRQ_EN
    if (pe && h_of(n + 1) == 0 && v_of(n + 1) == VV) m_irq = 1;
    else if (irq_ack) m_irq = 0;
`endif
    if (pe) begin
      m_hs = hs_of(n - PD) ? 32'(HPOL) : 32'(!HPOL);
      m_vs = vs_of(n - PD) ? 32'(VPOL) : 32'(!VPOL);
      m_r  = act_of(n - PD) ? int'(pix_r_in) : 0;
      m_g  = act_of(n - PD) ? int'(pix_g_in) : 0;
      m_b  = act_of(n - PD) ? int'(pix_b_in) : 0;
      if ((n + 1) % (HT * VT) == 0) m_mode = int'(double_scan_req);
    end
    m_clk++;
  endtask

  task automatic check_outputs();
    int n, h, v;
    n = m_clk / DIV;
    h = h_of(n);
    v = v_of(n);
    check("pix_en",      int'(pix_en),      int'((m_clk % DIV) == DIV - 1));
    check("pix_x",       int'(pix_x),       m_mode ? h / 2 : h);
    check("pix_y",       int'(pix_y),       m_mode ? v / 2 : v);
    check("pix_active",  int'(pix_active),  int'(act_of(n)));
    check("line_start",  int'(line_start),  m_ls);
    check("frame_start", int'(frame_start), m_fs);
    check("vga_hs",      int'(vga_hs),      m_hs);
    check("vga_vs",      int'(vga_vs),      m_vs);
    check("vga_r",       int'(vga_r),       m_r);
    check("vga_g",       int'(vga_g),       m_g);
    check("vga_b",       int'(vga_b),       m_b);
    check("irq",         int'(irq),         m_irq);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check_outputs();
    check("reset_hs_level", int'(vga_hs), int'(!HPOL));
    check("reset_vs_level", int'(vga_vs), int'(!VPOL));

    for (int c = 0; c < NCYC; c++) begin
      rst      = ($urandom_range(0, 2999) == 0);
      irq_ack  = ($urandom_range(0, 19) == 0);
      pix_r_in = CB'($urandom);
      pix_g_in = CB'($urandom);
      pix_b_in = CB'($urandom);
      if ($urandom_range(0, 99) == 0) double_scan_req = ~double_scan_req;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
